// File: rtl/uart_word_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | uart_word_arbiter_if : requester and UART transmitter side signals         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface uart_word_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]    req;
  logic [16*NUM_CH-1:0] data;
  logic [NUM_CH-1:0]    ack;
  logic                 tx_busy;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic [3:0]           grant_id;
  logic                 frame_busy;
  logic                 tx_timeout;

  modport master (
    input  req, data, tx_busy,
    output ack, tx_data, tx_start, grant_id, frame_busy, tx_timeout
  );

  modport slave (
    output req, data, tx_busy,
    input  ack, tx_data, tx_start, grant_id, frame_busy, tx_timeout
  );
endinterface

`default_nettype wire

// File: rtl/uart_word_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_word_arbiter : round-robin word arbiter and UART frame sequencer      |
// | Optional checksum byte enabled by macro UART_ARB_CHECKSUM_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_word_arbiter #(
  parameter int NUM_CH       = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  uart_word_arbiter_if.master bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEND    = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

`ifdef UART_ARB_CHECKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  localparam logic [7:0] TIMEOUT_C = 8'(BUSY_TIMEOUT);
  localparam logic [3:0] PTR_INIT  = 4'(NUM_CH - 1);

  logic [1:0]        r_state;
  logic [3:0]        r_ptr;
  logic [1:0]        r_idx;
  logic [7:0]        r_cnt;
  logic [15:0]       r_word;
  logic [NUM_CH-1:0] r_ack;
  logic [7:0]        r_tx_data;
  logic              r_tx_start;
  logic [3:0]        r_grant_id;
  logic              r_frame_busy;
  logic              r_tx_timeout;

  logic [NUM_CH-1:0] w_req_hi;
  logic [NUM_CH-1:0] w_onehot;
  logic [3:0]        w_sel_hi;
  logic [3:0]        w_sel_all;
  logic [3:0]        w_gnt;
  logic [15:0]       w_word;
  logic [7:0]        w_hdr;
  logic [7:0]        w_byte;

  // Requests above the pointer take precedence; otherwise wrap to the lowest.
  always_comb begin
    w_req_hi  = '0;
    w_sel_hi  = '0;
    w_sel_all = '0;
    w_onehot  = '0;
    w_word    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_req_hi[i] = bus.req[i] && (i > int'(r_ptr));
    end
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_req_hi[i]) w_sel_hi = 4'(i);
      if (bus.req[i])  w_sel_all = 4'(i);
    end
    w_gnt = (|w_req_hi) ? w_sel_hi : w_sel_all;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_gnt == 4'(i)) begin
        w_onehot[i] = 1'b1;
        w_word      = bus.data[16*i +: 16];
      end
    end
  end

  always_comb begin
    w_hdr = 8'hA0 | {4'h0, r_grant_id};
    case (r_idx)
      2'd0:    w_byte = w_hdr;
      2'd1:    w_byte = r_word[15:8];
      2'd2:    w_byte = r_word[7:0];
`ifdef UART_ARB_CHECKSUM_EN
      default: w_byte = w_hdr ^ r_word[15:8] ^ r_word[7:0];
`else
      default: w_byte = 8'h00;
`endif
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= PTR_INIT;
      r_idx        <= 2'd0;
      r_cnt        <= 8'd0;
      r_word       <= 16'd0;
      r_ack        <= '0;
      r_tx_data    <= 8'd0;
      r_tx_start   <= 1'b0;
      r_grant_id   <= 4'd0;
      r_frame_busy <= 1'b0;
      r_tx_timeout <= 1'b0;
    end else begin
      r_ack        <= '0;
      r_tx_start   <= 1'b0;
      r_tx_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_word       <= w_word;
            r_ack        <= w_onehot;
            r_grant_id   <= w_gnt;
            r_ptr        <= w_gnt;
            r_frame_busy <= 1'b1;
            r_idx        <= 2'd0;
            r_state      <= S_SEND;
          end else begin
            r_tx_data    <= 8'd0;
            r_frame_busy <= 1'b0;
          end
        end
        S_SEND: begin
          if (!bus.tx_busy) begin
            r_tx_data  <= w_byte;
            r_tx_start <= 1'b1;
            r_cnt      <= 8'd0;
            r_state    <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          // A busy rise in the expiry cycle wins over the timeout.
          if (bus.tx_busy) begin
            r_state <= S_WAIT_LO;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (r_cnt + 8'd1 == TIMEOUT_C) begin
              r_tx_timeout <= 1'b1;
              r_state      <= S_WAIT_LO;
            end
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (r_idx == LAST_IDX) begin
              r_frame_busy <= 1'b0;
              r_state      <= S_IDLE;
            end else begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.tx_data    = r_tx_data;
  assign bus.tx_start   = r_tx_start;
  assign bus.grant_id   = r_grant_id;
  assign bus.frame_busy = r_frame_busy;
  assign bus.tx_timeout = r_tx_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_uart_word_arbiter : directed bench with a simple UART busy model        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_word_arbiter;

`ifdef UART_ARB_CHECKSUM_EN
  localparam int NBYTES = 4;
`else
  localparam int NBYTES = 3;
`endif
  localparam logic [63:0] DATA_DEF = {16'hFF00, 16'h3C5A, 16'h12AB, 16'h0F01};

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [3:0]  req_after;
    logic [3:0]  exp_ack;
    logic [3:0]  exp_gid;
    logic [31:0] exp_bytes;
    bit          mangle;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] mode;
  int bcnt;
  int checks = 0;
  int errors = 0;
  int tout_cnt = 0;
  logic [7:0] bytes_q[$];
  vec_t vecs[9];

  uart_word_arbiter_if #(.NUM_CH(4)) bus ();

  uart_word_arbiter #(.NUM_CH(4), .BUSY_TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // mode 0: busy for 10 cycles starting one cycle after tx_start; 1: stuck 0; 2: stuck 1
  always @(posedge clk) begin
    if (reset) begin
      bus.tx_busy <= 1'b0;
      bcnt        <= 0;
    end else if (mode == 2'd2) begin
      bus.tx_busy <= 1'b1;
    end else if (mode == 2'd1) begin
      bus.tx_busy <= 1'b0;
    end else if (bus.tx_start) begin
      bus.tx_busy <= 1'b1;
      bcnt        <= 9;
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
    end else begin
      bus.tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.tx_start) bytes_q.push_back(bus.tx_data);
    if (bus.tx_timeout) tout_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit r, logic [3:0] rq, logic [3:0] ra, logic [3:0] ea,
                              logic [3:0] g, logic [31:0] b, bit mg);
    vec_t v;
    v.rst = r; v.req = rq; v.req_after = ra; v.exp_ack = ea;
    v.exp_gid = g; v.exp_bytes = b; v.mangle = mg;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_ack", {28'd0, bus.ack}, 32'd0);
    check("rst_grant_id", {28'd0, bus.grant_id}, 32'd0);
    check("rst_frame_busy", {31'd0, bus.frame_busy}, 32'd0);
    check("rst_tx_timeout", {31'd0, bus.tx_timeout}, 32'd0);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack == 4'd0 && n < 200);
    if (bus.ack == 4'd0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tx_start && n < 60);
    check("start_seen", {31'd0, bus.tx_start}, 32'd1);
  endtask

  task automatic wait_frame_end();
    int n = 0;
    while (bus.frame_busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("frame_end", {31'd0, bus.frame_busy}, 32'd0);
  endtask

  task automatic run_frame(input vec_t v);
    if (v.rst) do_reset();
    bus.req = v.req;
    wait_ack();
    check("ack", {28'd0, bus.ack}, {28'd0, v.exp_ack});
    check("grant_id", {28'd0, bus.grant_id}, {28'd0, v.exp_gid});
    check("frame_busy_on", {31'd0, bus.frame_busy}, 32'd1);
    bytes_q.delete();
    tout_cnt = 0;
    bus.req = v.req_after;
    if (v.mangle) bus.data = {4{16'hDEAD}};
    @(negedge clk);
    check("ack_width", {28'd0, bus.ack}, 32'd0);
    wait_frame_end();
    check("byte_count", 32'(bytes_q.size()), 32'(NBYTES));
    for (int i = 0; i < NBYTES; i++) begin
      if (i < bytes_q.size()) check("byte", {24'd0, bytes_q[i]}, {24'd0, v.exp_bytes[8*i +: 8]});
    end
    check("no_timeout", 32'(tout_cnt), 32'd0);
    bus.data = DATA_DEF;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int strobes;
    int k;
    bit saw;
    reset    = 1'b1;
    mode     = 2'd0;
    bus.req  = 4'd0;
    bus.data = DATA_DEF;

    vecs[0] = mk(1, 4'b0010, 4'b0000, 4'b0010, 4'd1, 32'h18AB12A1, 1);
    vecs[1] = mk(1, 4'b1111, 4'b1111, 4'b0001, 4'd0, 32'hAE010FA0, 0);
    vecs[2] = mk(0, 4'b1111, 4'b1111, 4'b0010, 4'd1, 32'h18AB12A1, 0);
    vecs[3] = mk(0, 4'b1111, 4'b1111, 4'b0100, 4'd2, 32'hC45A3CA2, 0);
    vecs[4] = mk(0, 4'b1111, 4'b1111, 4'b1000, 4'd3, 32'h5C00FFA3, 0);
    vecs[5] = mk(0, 4'b1111, 4'b0000, 4'b0001, 4'd0, 32'hAE010FA0, 0);
    vecs[6] = mk(1, 4'b0100, 4'b1001, 4'b0100, 4'd2, 32'hC45A3CA2, 0);
    vecs[7] = mk(0, 4'b1001, 4'b0001, 4'b1000, 4'd3, 32'h5C00FFA3, 0);
    vecs[8] = mk(0, 4'b0001, 4'b0000, 4'b0001, 4'd0, 32'hAE010FA0, 0);

    for (int i = 0; i < 9; i++) run_frame(vecs[i]);

    // Transmitter busy before the request: strobe waits, then is one cycle wide.
    do_reset();
    mode = 2'd2;
    repeat (2) @(negedge clk);
    bus.req = 4'b0001;
    wait_ack();
    bus.req = 4'b0000;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.tx_start) saw = 1'b1;
    end
    check("start_while_busy", {31'd0, saw}, 32'd0);
    mode = 2'd0;
    wait_start();
    @(negedge clk);
    check("start_width", {31'd0, bus.tx_start}, 32'd0);
    wait_frame_end();

    // Dead transmitter: every byte times out 15 cycles after its strobe.
    do_reset();
    mode = 2'd1;
    bus.req = 4'b0001;
    wait_ack();
    bus.req = 4'b0000;
    strobes = 0;
    for (int b = 0; b < NBYTES; b++) begin
      wait_start();
      if (bus.tx_start) strobes++;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!bus.tx_timeout && k < 40);
      check("timeout_delay", 32'(k), 32'd15);
    end
    check("dead_strobes", 32'(strobes), 32'(NBYTES));
    wait_frame_end();
    mode = 2'd0;

    // Reset after the high byte strobe aborts the frame and restores the pointer.
    do_reset();
    bus.req = 4'b0100;
    wait_ack();
    bus.req = 4'b0000;
    wait_start();
    repeat (2) @(negedge clk);
    wait_start();
    do_reset();
    saw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.tx_start) saw = 1'b1;
    end
    check("start_after_reset", {31'd0, saw}, 32'd0);
    run_frame(mk(0, 4'b1001, 4'b0000, 4'b0001, 4'd0, 32'hAE010FA0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_word_arbiter.md
# uart_word_arbiter

Round-robin arbiter and frame sequencer that shares the single byte-wide UART transmitter between several 16-bit word producers, such as MEMS SPI readout channels. It grants one requester at a time and captures that requester's word. It then drives the transmitter through a framed byte sequence: a channel header, the high byte, the low byte, and an optional checksum. Each byte is handed over with a start strobe and completion is tracked via the transmitter's busy line.

## Interface
- NUM_CH, 4: number of requesters, 2..16
- BUSY_TIMEOUT, 15: cycles to wait for tx_busy to rise after tx_start before forcing progress, 1..255
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NUM_CH  level request per channel; held until ack
- data  in  16*NUM_CH  word per channel; channel i at [16*i+15:16*i]
- ack  out  NUM_CH  one-cycle pulse on the granted bit when its word is captured
- tx_busy  in  1  UART transmitter busy
- tx_data  out  8  byte to transmitter
- tx_start  out  1  one-cycle strobe: transmitter loads tx_data
- grant_id  out  4  channel of the current or last frame
- frame_busy  out  1  high from capture until the last byte completes
- tx_timeout  out  1  one-cycle pulse when BUSY_TIMEOUT expires

## Operation
- Reset values: tx_data=0, tx_start=0, ack=0, grant_id=0, frame_busy=0, tx_timeout=0, state IDLE, rr pointer=NUM_CH-1, byte index=0, timeout counter=0.
- States: IDLE, SEND, WAIT_HI, WAIT_LO.
- IDLE: if any req bit is set, grant the first set bit searching upward from pointer+1 (mod NUM_CH).
  - Capture the word; pulse ack[g]; set grant_id=g, pointer=g, frame_busy=1, index=0; go to SEND.
  - With no request: tx_data=0 and frame_busy=0.
- Frame bytes by index:
  - 0: 8'hA0 | grant_id
  - 1: word[15:8]
  - 2: word[7:0]
  - 3 (macro only): checksum
- SEND: when tx_busy=0, drive tx_data=byte[index] and tx_start=1 for exactly one cycle, clear the counter, go to WAIT_HI. When tx_busy=1, hold.
- WAIT_HI: when tx_busy=1, go to WAIT_LO.
  - Otherwise increment the counter. When it reaches BUSY_TIMEOUT, pulse tx_timeout and go to WAIT_LO.
- WAIT_LO: when tx_busy=0:
  - If index is the last byte: go to IDLE and clear frame_busy.
  - Else: index+1, go to SEND.
- tx_data holds the current byte from SEND through WAIT_LO.
- The captured word is immune to later data/req changes. Dropping req mid-frame does not abort the frame.
- A request asserted during a frame waits. After a frame from channel g, a requesting channel g+1 wins over g.
- Reset mid-frame aborts immediately. No partial byte strobes follow reset.

## Timing
- Capture: req seen in IDLE at edge n → ack high and state SEND during cycle n+1.
- tx_start is asserted in cycle n+2 at the earliest (SEND with tx_busy=0).
- Minimum gap between consecutive tx_start strobes: 3 cycles (SEND, WAIT_HI, WAIT_LO each take at least one cycle).
- End of frame: IDLE is re-entered one cycle after tx_busy falls on the last byte. The next grant occurs on the following edge.
- Simultaneous tx_busy rise and timeout expiry: busy wins, no tx_timeout pulse.
- ack never asserts for more than one bit or for more than one cycle per frame.

## Configuration
- UART_ARB_CHECKSUM_EN defined: 4-byte frames. Byte 3 = header ^ word[15:8] ^ word[7:0].
- Undefined: 3-byte frames; last index is 2.

## Test plan
- Single word: reset, req[1]=1 with data ch1=16'h12AB, UART model busy for 10 cycles starting 1 cycle after tx_start.
  - Expect ack[1] one pulse, then bytes A1, 12, AB.
  - With the macro, also byte 18 (A1^12^AB).
  - Expect frame_busy to drop after the last byte.
- Round robin: req=4'b1111 held, reacking each granted channel.
  - Expect grant order 0,1,2,3,0.
  - Expect headers A0,A1,A2,A3,A0.
- Contention after grant: ch2 in frame, ch0 and ch3 assert.
  - Expect next grant ch3, then ch0.
- Busy held high: tx_busy=1 before request.
  - Expect no tx_start until tx_busy=0.
  - Then tx_start exactly 1 cycle wide.
- Dead transmitter: tx_busy stuck 0.
  - Expect tx_timeout pulse 15 cycles after each tx_start.
  - Expect the frame to complete: 3 strobes, or 4 with the macro.
- Reset mid-frame after the hi byte: assert reset 1 cycle.
  - Expect all outputs 0 the next cycle.
  - Expect no further tx_start until a new req arrives.
  - Expect ch0 to have priority.
